// File: rtl/ysyx_22041752_multer.sv
// Iterative radix-2 shift-add multiplier for the RV64M multiply group
// (MUL, MULH, MULHSU, MULHU, MULW). One partial-product step per cycle over
// a valid/ready handshake; the product is held until EXU takes it.
module ysyx_22041752_multer #(
   parameter int DATA_WD = 64
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               flush,
   input  logic               mul_valid,
   output logic               mul_ready,
   input  logic [DATA_WD-1:0] multiplicand,
   input  logic [DATA_WD-1:0] multiplier,
   input  logic [1:0]         mul_signed,
   input  logic               mulw,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_WD-1:0] result_hi,
   output logic [DATA_WD-1:0] result_lo
);

   localparam int ACC_WD = 2 * DATA_WD;
   localparam int CNT_WD = $clog2(DATA_WD) + 1;
   localparam int W_WD   = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_WD-1:0]  mcand_q;      // |A|, added into the upper half
   logic [DATA_WD-1:0]  mplier_q;     // |B|, consumed one bit per step from the LSB
   logic [ACC_WD-1:0]   acc_q;
   logic [CNT_WD-1:0]   cnt_q;
   logic                neg_q;
   logic                mulw_q;

   // Operand conditioning at accept time. MULW truncates to 32 bits and
   // works unsigned: only the low 32 product bits survive, which are the
   // same for signed and unsigned interpretations.
   logic               a_neg, b_neg;
   logic [DATA_WD-1:0] a_in, b_in, a_abs, b_abs;

   assign a_in  = mulw ? {{(DATA_WD-W_WD){1'b0}}, multiplicand[W_WD-1:0]} : multiplicand;
   assign b_in  = mulw ? {{(DATA_WD-W_WD){1'b0}}, multiplier[W_WD-1:0]}   : multiplier;
   assign a_neg = ~mulw & mul_signed[1] & multiplicand[DATA_WD-1];
   assign b_neg = ~mulw & mul_signed[0] & multiplier[DATA_WD-1];
   assign a_abs = a_neg ? (~a_in + 1'b1) : a_in;
   assign b_abs = b_neg ? (~b_in + 1'b1) : b_in;

   // Status outputs decode registered state only.
   assign mul_ready = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

   logic accept, last_iter;
   logic [CNT_WD-1:0] last_cnt;

   assign accept    = mul_valid & mul_ready & ~flush;
   assign last_cnt  = mulw_q ? CNT_WD'(W_WD - 1) : CNT_WD'(DATA_WD - 1);
   assign last_iter = (state_q == BUSY) && (cnt_q == last_cnt);

   // One iteration: conditional add into the upper half with a carry bit,
   // then shift the 129-bit {carry, acc} right by one.
   logic [DATA_WD:0]   sum;
   logic [ACC_WD-1:0]  acc_next;
   logic [ACC_WD-1:0]  prod_raw, prod;
   logic [DATA_WD-1:0] res_hi, res_lo;

   assign sum      = {1'b0, acc_q[ACC_WD-1:DATA_WD]}
                   + (mplier_q[0] ? {1'b0, mcand_q} : '0);
   assign acc_next = ACC_WD'({sum, acc_q[DATA_WD-1:0]} >> 1);

   // After 32 steps the word product sits 32 bits up; realign it to bit 0.
   assign prod_raw = mulw_q ? (acc_next >> W_WD) : acc_next;
   assign prod     = neg_q ? (~prod_raw + 1'b1) : prod_raw;
   assign res_lo   = mulw_q ? {{(DATA_WD-W_WD){prod[W_WD-1]}}, prod[W_WD-1:0]}
                            : prod[DATA_WD-1:0];
   assign res_hi   = mulw_q ? {DATA_WD{prod[W_WD-1]}} : prod[ACC_WD-1:DATA_WD];

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; flush wins over any handshake in progress.
   always_comb begin
      // NOTE: default assigned first so no path leaves state_d unassigned,
      // which would otherwise infer a latch.
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (mul_valid) state_d = BUSY;
            BUSY:    if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Datapath: latch operands on accept, iterate in BUSY, capture the
   // signed-corrected product on the edge that completes the last step.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         mulw_q    <= 1'b0;
         result_hi <= '0;
         result_lo <= '0;
      end else if (accept) begin
         mcand_q  <= a_abs;
         mplier_q <= b_abs;
         neg_q    <= a_neg ^ b_neg;
         mulw_q   <= mulw;
         cnt_q    <= '0;
         acc_q    <= '0;
      end else if ((state_q == BUSY) && !flush) begin
         acc_q    <= acc_next;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CNT_WD'(1);
         if (last_iter) begin
            result_hi <= res_hi;
            result_lo <= res_lo;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22041752_multer.sv
// Self-checking bench for ysyx_22041752_multer: directed cases plus random
// operations compared against an arithmetic reference model.
module tb_ysyx_22041752_multer;

   logic        clk;
   logic        resetn;
   logic        flush;
   logic        mul_valid;
   logic        mul_ready;
   logic [63:0] multiplicand;
   logic [63:0] multiplier;
   logic [1:0]  mul_signed;
   logic        mulw;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result_hi;
   logic [63:0] result_lo;

   int checks = 0;
   int errors = 0;

   ysyx_22041752_multer #(.DATA_WD(64)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .flush        (flush),
      .mul_valid    (mul_valid),
      .mul_ready    (mul_ready),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .mul_signed   (mul_signed),
      .mulw         (mulw),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result_hi    (result_hi),
      .result_lo    (result_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: full-width integer product of the extended operands.
   function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] s, input logic w);
      logic [127:0] ea, eb;
      logic [63:0]  p;
      if (w) begin
         p = {32'b0, a[31:0]} * {32'b0, b[31:0]};
         return {{64{p[31]}}, {32{p[31]}}, p[31:0]};
      end
      ea = s[1] ? {{64{a[63]}}, a} : {64'b0, a};
      eb = s[0] ? {{64{b[63]}}, b} : {64'b0, b};
      return ea * eb;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, scramble operands after accept, measure latency,
   // compare the product and complete the result handshake.
   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] s, input logic w);
      int lat;
      multiplicand = a;
      multiplier   = b;
      mul_signed   = s;
      mulw         = w;
      mul_valid    = 1'b1;
      tick();
      mul_valid    = 1'b0;
      multiplicand = {$urandom, $urandom};
      multiplier   = {$urandom, $urandom};
      mul_signed   = 2'($urandom_range(0, 3));
      mulw         = ~w;
      lat = 0;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, 128'(lat), w ? 128'd32 : 128'd64);
      check({tag, "_prod"}, {result_hi, result_lo}, model(a, b, s, w));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_idle"}, {126'b0, mul_ready, out_valid}, 128'b10);
   endtask

   initial begin
      logic [63:0] hold_hi, hold_lo;
      int seen;
      resetn       = 1'b0;
      flush        = 1'b0;
      mul_valid    = 1'b0;
      out_ready    = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      mul_signed   = 2'b00;
      mulw         = 1'b0;
      #12;
      check("reset_status", {126'b0, mul_ready, out_valid}, 128'b10);
      check("reset_result", {result_hi, result_lo}, 128'b0);
      @(negedge clk);
      resetn = 1'b1;
      tick();

      // Directed cases.
      run_op("mulhu_3x5", 64'd3, 64'd5, 2'b00, 1'b0);
      check("mulhu_3x5_lo", 128'(result_lo), 128'd15);
      run_op("mulh_m1sq", '1, '1, 2'b11, 1'b0);
      run_op("mulhu_m1sq", '1, '1, 2'b00, 1'b0);
      check("mulhu_m1sq_hi", 128'(result_hi), 128'hFFFF_FFFF_FFFF_FFFE);
      run_op("mulhsu_m1x2", '1, 64'd2, 2'b10, 1'b0);
      run_op("mulh_min_m1", 64'h8000_0000_0000_0000, '1, 2'b11, 1'b0);
      check("mulh_min_m1_lo", 128'(result_lo), 128'h8000_0000_0000_0000);
      run_op("mulw_ovf", 64'h0000_0000_7FFF_FFFF, 64'd2, 2'b00, 1'b1);
      check("mulw_ovf_lo", 128'(result_lo), 128'hFFFF_FFFF_FFFF_FFFE);
      run_op("mulw_garbage", 64'hDEAD_BEEF_0000_0003, 64'h1234_5678_0000_0005, 2'b11, 1'b1);
      run_op("zero_op", 64'd0, 64'd5, 2'b11, 1'b0);

      // Flush during iteration 10 aborts the operation.
      multiplicand = 64'd9;
      multiplier   = 64'd9;
      mul_signed   = 2'b00;
      mulw         = 1'b0;
      mul_valid    = 1'b1;
      tick();
      mul_valid = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_idle", {126'b0, mul_ready, out_valid}, 128'b10);
      seen = 0;
      repeat (70) begin
         tick();
         if (out_valid) seen++;
      end
      check("flush_no_result", 128'(seen), 128'd0);
      run_op("after_flush_7x6", 64'd7, 64'd6, 2'b00, 1'b0);

      // Flush beats a simultaneous accept.
      mul_valid = 1'b1;
      flush     = 1'b1;
      tick();
      mul_valid = 1'b0;
      flush     = 1'b0;
      check("flush_vs_accept", {126'b0, mul_ready, out_valid}, 128'b10);
      seen = 0;
      repeat (70) begin
         tick();
         if (out_valid) seen++;
      end
      check("flush_vs_accept_none", 128'(seen), 128'd0);

      // Backpressure: result held, new requests ignored.
      multiplicand = 64'h0123_4567_89AB_CDEF;
      multiplier   = 64'hFEDC_BA98_7654_3210;
      mul_signed   = 2'b11;
      mulw         = 1'b0;
      mul_valid    = 1'b1;
      tick();
      mul_valid = 1'b0;
      seen = 0;
      while (!out_valid && seen < 200) begin
         tick();
         seen++;
      end
      check("bp_lat", 128'(seen), 128'd64);
      check("bp_prod", {result_hi, result_lo},
            model(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 2'b11, 1'b0));
      hold_hi      = result_hi;
      hold_lo      = result_lo;
      multiplicand = 64'd1;
      multiplier   = 64'd1;
      mul_valid    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("bp_hold%0d", i), {result_hi, result_lo}, {hold_hi, hold_lo});
         check($sformatf("bp_status%0d", i), {126'b0, mul_ready, out_valid}, 128'b01);
      end
      mul_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_release", {126'b0, mul_ready, out_valid}, 128'b10);

      // Random operations against the reference model.
      for (int i = 0; i < 24; i++) begin
         logic [63:0] ra, rb;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if ($urandom_range(0, 5) == 0) ra = 64'h8000_0000_0000_0000;
         if ($urandom_range(0, 5) == 0) rb = '1;
         run_op($sformatf("rand%0d", i), ra, rb, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
      end

      // Asynchronous reset mid-BUSY, with a non-zero result held beforehand.
      run_op("pre_reset", 64'd3, 64'd5, 2'b00, 1'b0);
      multiplicand = 64'd11;
      multiplier   = 64'd13;
      mul_valid    = 1'b1;
      tick();
      mul_valid = 1'b0;
      repeat (20) tick();
      #2;
      resetn = 1'b0;
      #1;
      check("async_status", {126'b0, mul_ready, out_valid}, 128'b10);
      check("async_result", {result_hi, result_lo}, 128'b0);
      @(negedge clk);
      resetn = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
